// File: rtl/mbist_repair_unload_pkg.sv
// Shared MBIST definitions: chain geometry defaults and the unload FSM state type.
package mbist_repair_unload_pkg;

    localparam int unsigned BIST_ERR_LIMIT = 4;
    localparam int unsigned BIST_SHIFT_WD  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } unload_state_e;

endpackage

// File: rtl/mbist_repair_unload_fifo.sv
// Synchronous FIFO holding recovered {index, address} repair entries.
module mbist_repair_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_WD = $clog2(DEPTH);
    localparam int unsigned CNT_WD = $clog2(DEPTH+1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_WD-1:0] wr_ptr;
    logic [PTR_WD-1:0] rd_ptr;
    logic              push_en;
    logic              pop_en;

    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign full     = (count == CNT_WD'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_WD'(1);
            end
            if (pop_en) rd_ptr <= rd_ptr + PTR_WD'(1);
            unique case ({push_en, pop_en})
                2'b10:   count <= count + CNT_WD'(1);
                2'b01:   count <= count - CNT_WD'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mbist_repair_unload.sv
// Unloads the MBIST repair-address chain: load pulse, shift, deserialize, queue entries.
module mbist_repair_unload
    import mbist_repair_unload_pkg::*;
#(
    parameter int unsigned ERR_LIMIT  = BIST_ERR_LIMIT,
    parameter int unsigned SHIFT_WD   = BIST_SHIFT_WD,
    parameter int unsigned ADDR_WD    = 9,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         loopback,
    output logic                         busy,
    output logic                         done,
    output logic                         bist_load,
    output logic                         bist_shift,
    input  logic                         chain_sdo,
    output logic                         chain_sdi,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [ADDR_WD-1:0]           rd_data,
    output logic [$clog2(ERR_LIMIT)-1:0] rd_index
);

    localparam int unsigned IDX_WD  = $clog2(ERR_LIMIT);
    localparam int unsigned BIT_WD  = $clog2(SHIFT_WD);
    localparam int unsigned FIFO_WD = ADDR_WD + IDX_WD;
    localparam int unsigned CNT_WD  = $clog2(FIFO_DEPTH+1);

    unload_state_e      state;
    unload_state_e      state_next;
    logic [BIT_WD-1:0]  bit_cnt;
    logic [IDX_WD-1:0]  entry_cnt;
    // Only the bits that survive truncation to ADDR_WD are kept.
    logic [ADDR_WD-2:0] deser;
    logic [ADDR_WD-1:0] deser_next;
    logic               last_bit;
    logic               last_entry;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_WD-1:0]  fifo_count;
    logic [FIFO_WD-1:0] push_data;
    logic [FIFO_WD-1:0] pop_data;
    logic               unused_count;

    assign bist_shift   = (state == ST_SHIFT) && !fifo_full;
    assign chain_sdi    = loopback & chain_sdo;
    assign deser_next   = {deser, chain_sdo};
    assign last_bit     = (bit_cnt == BIT_WD'(SHIFT_WD-1));
    assign last_entry   = (entry_cnt == IDX_WD'(ERR_LIMIT-1));
    assign push         = bist_shift && last_bit;
    assign push_data    = {IDX_WD'(ERR_LIMIT-1) - entry_cnt, deser_next};
    assign pop          = rd_valid && rd_ready;
    assign rd_valid     = !fifo_empty;
    assign rd_index     = pop_data[FIFO_WD-1:ADDR_WD];
    assign rd_data      = pop_data[ADDR_WD-1:0];
    assign unused_count = &{1'b0, fifo_count};

    // Next-state decode.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: if (push && last_entry) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register and registered status/strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bist_load <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next == ST_LOAD) || (state_next == ST_SHIFT);
            done      <= (state_next == ST_DONE);
            bist_load <= (state_next == ST_LOAD);
        end
    end

    // Bit/entry counters and deserializer; everything holds while the FIFO is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            entry_cnt <= '0;
            deser     <= '0;
        end else if (state == ST_LOAD) begin
            bit_cnt   <= '0;
            entry_cnt <= '0;
            deser     <= '0;
        end else if (bist_shift) begin
            deser   <= deser_next[ADDR_WD-2:0];
            bit_cnt <= last_bit ? '0 : bit_cnt + BIT_WD'(1);
            if (last_bit) entry_cnt <= last_entry ? '0 : entry_cnt + IDX_WD'(1);
        end
    end

    mbist_repair_fifo #(
        .WIDTH (FIFO_WD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mbist_repair_unload.sv
// Scoreboard bench for mbist_repair_unload with a behavioural repair-address chain.
module tb_mbist_repair_unload;

    localparam int unsigned EL = 4;
    localparam int unsigned SW = 16;
    localparam int unsigned AW = 9;
    localparam int unsigned FD = 2;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          loopback;
    logic          busy;
    logic          done;
    logic          bist_load;
    logic          bist_shift;
    logic          chain_sdo;
    logic          chain_sdi;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_data;
    logic [IW-1:0] rd_index;

    logic [SW-1:0] src [EL];
    logic [SW-1:0] stg [EL] = '{default: '0};
    logic [IW+AW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int pop_cnt = 0;

    always #5 clk = ~clk;

    mbist_repair_unload #(
        .ERR_LIMIT  (EL),
        .SHIFT_WD   (SW),
        .ADDR_WD    (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .loopback   (loopback),
        .busy       (busy),
        .done       (done),
        .bist_load  (bist_load),
        .bist_shift (bist_shift),
        .chain_sdo  (chain_sdo),
        .chain_sdi  (chain_sdi),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_index   (rd_index)
    );

    // Chain model: parallel load from src, MSB-first shift through the daisy chain.
    assign chain_sdo = stg[EL-1][SW-1];
    always @(posedge clk) begin
        if (bist_load) begin
            for (int i = 0; i < int'(EL); i++) stg[i] <= src[i];
            load_cnt <= load_cnt + 1;
        end else if (bist_shift) begin
            stg[0] <= {stg[0][SW-2:0], chain_sdi};
            for (int i = 1; i < int'(EL); i++) stg[i] <= {stg[i][SW-2:0], stg[i-1][SW-1]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted FIFO output is compared against the scoreboard head.
    always @(negedge clk) begin
        logic [IW+AW-1:0] e;
        if (rst_n && rd_valid && rd_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'(rd_index), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rd_index", 32'(rd_index), 32'(e[IW+AW-1:AW]));
                chk("rd_data", 32'(rd_data), 32'(e[AW-1:0]));
            end
        end
    end

    task automatic expect_all();
        for (int e = int'(EL) - 1; e >= 0; e--) exp_q.push_back({IW'(e), src[e][AW-1:0]});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One unload; optional start pokes, stall release and cycle-exact timing checks.
    task automatic run_unload(input bit timed, input int poke_at, input bit poke_done,
                              input int release_at);
        int n = 0;
        int first_v = -1;
        bit got = 1'b0;
        expect_all();
        pulse_start();
        chk("bist_load_e0", 32'(bist_load), 32'd1);
        chk("busy_load", 32'(busy), 32'd1);
        while (!got && n < 3000) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (n == 1) chk("bist_shift_e1", 32'(bist_shift), 32'd1);
            if (n == 2 && timed) chk("bist_load_once", 32'(bist_load), 32'd0);
            if (n == poke_at) start = 1'b1;
            if (release_at > 0 && n == release_at - 1) begin
                chk("stall_shift_low", 32'(bist_shift), 32'd0);
                chk("stall_busy", 32'(busy), 32'd1);
                chk("stall_valid", 32'(rd_valid), 32'd1);
            end
            if (release_at > 0 && n == release_at) rd_ready = 1'b1;
            if (rd_valid && first_v < 0) first_v = n;
            if (done) got = 1'b1;
        end
        chk("done_seen", 32'(got), 32'd1);
        if (timed) begin
            chk("done_cycle", 32'(n), 32'd65);
            chk("first_valid_cycle", 32'(first_v), 32'd17);
        end
        if (poke_done) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_chain(input bit intact);
        for (int i = 0; i < int'(EL); i++)
            chk(intact ? "chain_intact" : "chain_zero", 32'(stg[i]), intact ? 32'(src[i]) : 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bist_load", 32'(bist_load), 32'd0);
        chk("rst_bist_shift", 32'(bist_shift), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_index", 32'(rd_index), 32'd0);
    endtask

    initial begin
        int lc;
        rst_n    = 1'b0;
        start    = 1'b0;
        loopback = 1'b0;
        rd_ready = 1'b1;
        src[0] = 16'h0003;
        src[1] = 16'h01F0;
        src[2] = 16'h0155;
        src[3] = 16'h00AA;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs();
        rst_n = 1'b1;

        // Destructive unload, exact timing.
        run_unload(1'b1, 0, 1'b0, 0);
        drain();
        chk_chain(1'b0);

        // Two back-to-back loopback unloads.
        loopback = 1'b1;
        run_unload(1'b1, 0, 1'b0, 0);
        run_unload(1'b1, 0, 1'b0, 0);
        drain();
        chk_chain(1'b1);
        loopback = 1'b0;

        // Backpressure: FIFO of two fills and shifting stalls until released.
        rd_ready = 1'b0;
        run_unload(1'b0, 0, 1'b0, 80);
        drain();
        chk_chain(1'b0);

        // start during SHIFT and DONE is ignored.
        lc = load_cnt;
        pop_cnt = 0;
        run_unload(1'b1, 30, 1'b1, 0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("single_load", 32'(load_cnt - lc), 32'd1);
        chk("pop_count", 32'(pop_cnt), 32'd4);
        chk("idle_after_pokes", 32'(busy), 32'd0);

        // Reset after 20 shift cycles discards partial work.
        expect_all();
        pulse_start();
        repeat (21) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs();
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        run_unload(1'b1, 0, 1'b0, 0);
        drain();

        // Upper stage bits are truncated to the address width.
        src[3] = 16'hFEAA;
        src[0] = 16'hFFFF;
        run_unload(1'b1, 0, 1'b0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
